// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings,
// sign-bit position lookup and the stage-1 register bundle.
package imm_ext_pkg;

  localparam logic [2:0] MODE_IMM8   = 3'b000;
  localparam logic [2:0] MODE_IMM12  = 3'b001;
  localparam logic [2:0] MODE_IMM24  = 3'b010;
  localparam logic [2:0] MODE_SPLIT8 = 3'b011;
  localparam logic [2:0] MODE_ROT    = 3'b100;
  localparam logic [2:0] MODE_BRANCH = 3'b101;

  typedef struct packed {
    logic [23:0] raw;    // extracted field, right-aligned
    logic [2:0]  mode;
    logic        sgn;
    logic [3:0]  rot;    // rotate field, amount is 2*rot
    logic        carry;  // latched CPSR C
    logic        err;    // illegal mode
  } s1_t;

  function automatic logic [4:0] sign_pos(input logic [2:0] mode);
    case (mode)
      MODE_IMM12:              sign_pos = 5'd11;
      MODE_IMM24, MODE_BRANCH: sign_pos = 5'd23;
      default:                 sign_pos = 5'd7;
    endcase
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side and ALU-side handshake bundle for imm_extend_pipe.
interface imm_extend_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_mode;
  logic             in_signed;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_imm;
  logic             out_carry;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_mode, in_signed, in_carry, out_ready,
    input  in_ready, out_valid, out_imm, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_mode, in_signed, in_carry, out_ready,
    output in_ready, out_valid, out_imm, out_carry, out_err
  );
endinterface

// File: rtl/imm_rotator.sv
// ARM rotated-immediate expansion: 8-bit value rotated right by 2*rot within
// 32 bits, with shifter carry-out (carry-in passes through when rot is 0).
module imm_rotator (
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [31:0] val;
  logic [4:0]  amt;

  always_comb begin
    val       = {24'b0, imm8};
    amt       = {rot, 1'b0};
    // Shifting the doubled word right gives a rotate in its low half.
    result    = 32'({val, val} >> amt);
    carry_out = (rot == 4'd0) ? carry_in : result[31];
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator: stage 1 extracts the field, stage 2 extends,
// rotates or scales it. Valid/ready on both sides, optional flush.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FLUSH_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imm_extend_pipe_if.slave   bus
);

  if (WIDTH < 32) begin : g_width_check
    $error("imm_extend_pipe: WIDTH must be at least 32");
  end

  logic             flush_eff;
  logic             s1_valid, s2_valid;
  logic             adv1, adv2;
  s1_t              s1_q, s1_d;
  logic [WIDTH-1:0] s2_imm;
  logic             s2_carry, s2_err;
  logic [WIDTH-1:0] raw_w, ext, imm_d;
  logic             fill, carry_d;
  logic [4:0]       pos;
  logic [31:0]      rot_res;
  logic             rot_carry;
  logic             unused_instr_hi;

  assign flush_eff       = FLUSH_EN && flush;
  assign unused_instr_hi = ^bus.in_instr[31:24];

  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign bus.out_valid = s2_valid;
  assign bus.out_imm   = s2_imm;
  assign bus.out_carry = s2_carry;
  assign bus.out_err   = s2_err;

  always_comb begin
    s1_d       = '0;
    s1_d.mode  = bus.in_mode;
    s1_d.sgn   = bus.in_signed;
    s1_d.carry = bus.in_carry;
    s1_d.rot   = bus.in_instr[11:8];
    case (bus.in_mode)
      MODE_IMM8, MODE_ROT:     s1_d.raw = {16'b0, bus.in_instr[7:0]};
      MODE_IMM12:              s1_d.raw = {12'b0, bus.in_instr[11:0]};
      MODE_IMM24, MODE_BRANCH: s1_d.raw = bus.in_instr[23:0];
      MODE_SPLIT8:             s1_d.raw = {16'b0, bus.in_instr[11:8], bus.in_instr[3:0]};
      default:                 s1_d.err = 1'b1;
    endcase
  end

  imm_rotator u_rot (
    .imm8      (s1_q.raw[7:0]),
    .rot       (s1_q.rot),
    .carry_in  (s1_q.carry),
    .result    (rot_res),
    .carry_out (rot_carry)
  );

  always_comb begin
    raw_w = WIDTH'(s1_q.raw);
    pos   = sign_pos(s1_q.mode);
    // Branch is always signed, rot never is.
    fill  = s1_q.raw[pos] &
            ((s1_q.mode == MODE_BRANCH) | (s1_q.sgn & (s1_q.mode != MODE_ROT)));
    ext   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ext[i] = (i <= int'(pos)) ? raw_w[i] : fill;
    end
    imm_d   = ext;
    carry_d = s1_q.carry;
    if (s1_q.err) begin
      imm_d = '0;
    end else if (s1_q.mode == MODE_ROT) begin
      imm_d   = WIDTH'(rot_res);
      carry_d = rot_carry;
    end else if (s1_q.mode == MODE_BRANCH) begin
      imm_d = ext << 2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_imm   <= '0;
      s2_carry <= 1'b0;
      s2_err   <= 1'b0;
    end else if (flush_eff) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_imm   <= imm_d;
          s2_carry <= carry_d;
          s2_err   <= s1_q.err;
        end
      end
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q <= s1_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (WIDTH=32, flush enabled).
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.WIDTH(32)) bus ();

  imm_extend_pipe #(
    .WIDTH    (32),
    .FLUSH_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an idle pipe with out_ready high; samples after one and two edges.
  task automatic run_beat(input logic [31:0] instr, input logic [2:0] mode, input logic sgn,
                          input logic carry, output logic [31:0] imm, output logic c,
                          output logic e, output logic v, output logic v_early);
    bus.in_instr  = instr;
    bus.in_mode   = mode;
    bus.in_signed = sgn;
    bus.in_carry  = carry;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    v_early = bus.out_valid;
    tick();
    v   = bus.out_valid;
    imm = bus.out_imm;
    c   = bus.out_carry;
    e   = bus.out_err;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_mode   = '0;
    bus.in_signed = 1'b0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_imm !== 32'h0) begin
      errors++; $display("FAIL reset_out_imm: got %h want 00000000", bus.out_imm);
    end
    checks++;
    if (bus.out_carry !== 1'b0 || bus.out_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got carry=%b err=%b want 0 0", bus.out_carry,
                         bus.out_err);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_imm8();
    logic [31:0] imm;
    logic c, e, v, ve;
    run_beat(32'h00000080, 3'b000, 1'b1, 1'b1, imm, c, e, v, ve);
    checks++;
    if (ve !== 1'b0 || v !== 1'b1) begin
      errors++; $display("FAIL imm8_latency: got early=%b late=%b want 0 1", ve, v);
    end
    checks++;
    if (imm !== 32'hFFFFFF80 || c !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL imm8_signed: got %h c=%b e=%b want ffffff80 c=1 e=0", imm, c, e);
    end
    run_beat(32'h00000080, 3'b000, 1'b0, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h00000080 || c !== 1'b0) begin
      errors++; $display("FAIL imm8_unsigned: got v=%b %h c=%b want 1 00000080 0", v, imm, c);
    end
  endtask

  task automatic test_imm12_imm24();
    logic [31:0] imm;
    logic c, e, v, ve;
    run_beat(32'hFFFFF800, 3'b001, 1'b1, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'hFFFFF800) begin
      errors++; $display("FAIL imm12_signed: got v=%b %h want 1 fffff800", v, imm);
    end
    run_beat(32'hFFABCDEF, 3'b010, 1'b0, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h00ABCDEF) begin
      errors++; $display("FAIL imm24_unsigned: got v=%b %h want 1 00abcdef", v, imm);
    end
    run_beat(32'h00800001, 3'b010, 1'b1, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'hFF800001) begin
      errors++; $display("FAIL imm24_signed: got v=%b %h want 1 ff800001", v, imm);
    end
  endtask

  task automatic test_rot();
    logic [31:0] imm;
    logic c, e, v, ve;
    run_beat(32'h000004FF, 3'b100, 1'b1, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'hFF000000 || c !== 1'b1) begin
      errors++; $display("FAIL rot_by8: got v=%b %h c=%b want 1 ff000000 1", v, imm, c);
    end
    run_beat(32'h000000FF, 3'b100, 1'b1, 1'b1, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h000000FF || c !== 1'b1) begin
      errors++; $display("FAIL rot_zero: got v=%b %h c=%b want 1 000000ff 1", v, imm, c);
    end
    run_beat(32'h00000F81, 3'b100, 1'b0, 1'b1, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h00000204 || c !== 1'b0) begin
      errors++; $display("FAIL rot_by30: got v=%b %h c=%b want 1 00000204 0", v, imm, c);
    end
  endtask

  task automatic test_branch_split8();
    logic [31:0] imm;
    logic c, e, v, ve;
    run_beat(32'h00800000, 3'b101, 1'b0, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'hFE000000) begin
      errors++; $display("FAIL branch_neg: got v=%b %h want 1 fe000000", v, imm);
    end
    run_beat(32'h00000A05, 3'b011, 1'b1, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'hFFFFFFA5) begin
      errors++; $display("FAIL split8_signed: got v=%b %h want 1 ffffffa5", v, imm);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [4];
    logic [31:0] exp  [4];
    int sent = 0;
    int rcv  = 0;
    vals = '{32'h00000011, 32'h00000085, 32'h00000033, 32'h00000044};
    exp  = '{32'h00000011, 32'hFFFFFF85, 32'h00000033, 32'h00000044};
    bus.in_mode   = 3'b000;
    bus.in_signed = 1'b1;
    bus.in_carry  = 1'b0;
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      tick();
      bus.in_valid = (sent < 4);
      if (sent < 4) bus.in_instr = vals[sent];
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc == 2) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
        end
      end
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== exp[0]) begin
          errors++; $display("FAIL bp_hold: cyc %0d got v=%b %h want 1 %h", cyc, bus.out_valid,
                             bus.out_imm, exp[0]);
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_imm !== exp[rcv]) begin
          errors++; $display("FAIL bp_order: beat %0d got %h want %h", rcv, bus.out_imm, exp[rcv]);
        end
        rcv++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (rcv != 4) begin
      errors++; $display("FAIL bp_count: got %0d beats want 4", rcv);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL bp_dup: got out_valid=%b want 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    bus.in_mode   = 3'b000;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00000001;
    tick();
    bus.in_instr = 32'h00000002;
    tick();
    bus.in_instr = 32'h00000003;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_full: got out_valid=%b want 0", bus.out_valid);
    end
    // Single beat in stage 1, so in_ready reads high while the new beat is dropped.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00000004;
    tick();
    bus.in_instr = 32'h00000005;
    flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_partial: got out_valid=%b want 0", bus.out_valid);
    end
    bus.in_instr = 32'h0000007F;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after_early: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'h0000007F) begin
      errors++; $display("FAIL flush_after: got v=%b %h want 1 0000007f", bus.out_valid,
                         bus.out_imm);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_ghost: got %0d stray beats want 0", seen);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] imm;
    logic c, e, v, ve;
    run_beat(32'hFFFFFFFF, 3'b110, 1'b1, 1'b1, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h0 || e !== 1'b1 || c !== 1'b1) begin
      errors++; $display("FAIL illegal_110: got v=%b %h e=%b c=%b want 1 00000000 1 1", v, imm, e,
                         c);
    end
    run_beat(32'h000000FF, 3'b111, 1'b0, 1'b0, imm, c, e, v, ve);
    checks++;
    if (v !== 1'b1 || imm !== 32'h0 || e !== 1'b1 || c !== 1'b0) begin
      errors++; $display("FAIL illegal_111: got v=%b %h e=%b c=%b want 1 00000000 1 0", v, imm, e,
                         c);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 3'b110;
    bus.in_instr  = 32'h00000012;
    tick();
    bus.in_mode  = 3'b000;
    bus.in_instr = 32'h00000034;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.out_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v=%b %h e=%b want 0 00000000 0", bus.out_valid,
                         bus.out_imm, bus.out_err);
    end
    #14;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_ghost: got %0d beats after reset want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_imm8();
    test_imm12_imm24();
    test_rot();
    test_branch_split8();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
